clk_div_seq_ctrl: RTL and testbench

Sequencing controller for a 4-channel programmable clock divider running from the 10 MHz system clock.
- Holds a per-channel half-period register, written through a simple register port.
- Starts channels in a staggered order and stops them cleanly at a low phase, so no runt pulses reach downstream logic.
- Sits between the training-lab CPU/testbench register interface and the clock consumers.

---
 rtl/clk_div_seq_if.sv | 26 ++
 rtl/clk_div_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_div_seq_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_seq_if.sv
// Control/register bundle between the register-port driver and clk_div_seq_ctrl.
interface clk_div_seq_if #(
  parameter int NUM_CH = 4,
  parameter int HP_W   = 6
);
  logic              start;
  logic              stop;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [HP_W-1:0]   wr_data;
  logic [NUM_CH-1:0] clk_out;
  logic              running;
  logic              busy;
  logic              wr_err;
  logic              stopped;

  modport master (
    output start, stop, wr_en, wr_addr, wr_data,
    input  clk_out, running, busy, wr_err, stopped
  );

  modport slave (
    input  start, stop, wr_en, wr_addr, wr_data,
    output clk_out, running, busy, wr_err, stopped
  );
endinterface

// File: rtl/clk_div_seq_ctrl.sv
// Start/stop sequencer for a 4-channel programmable clock divider.
// Define CLK_DIV_SEQ_STAGGER_EN for START_GAP-spaced channel start; otherwise all channels start together.
module clk_div_seq_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int HP_W      = 6,
  parameter int HP_RST    = 5,
  parameter int START_GAP = 4
) (
  input logic          clk_in,
  input logic          rst_b,
  clk_div_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_STOP} state_t;

  state_t            state, state_nxt;
  logic [HP_W-1:0]   hp  [NUM_CH];
  logic [HP_W-1:0]   cnt [NUM_CH];
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] en_set;
  logic              launch;
  logic              all_started;
  logic              stopped_nxt;
  logic              wr_err_q;
  logic              stopped_q;

  if (START_GAP < 1 || START_GAP > 15) begin : g_gap_check
    $error("START_GAP must be in 1..15");
  end

`ifdef CLK_DIV_SEQ_STAGGER_EN
  logic [3:0] gap_cnt;
  logic [2:0] nxt_idx;
  logic       enable_next;

  assign all_started = (nxt_idx == 3'(NUM_CH));
  // stop has priority over a pending enable, so late channels stay off
  assign enable_next = (state == S_START) && !bus.stop && !all_started &&
                       (gap_cnt == 4'(START_GAP - 1));
  assign en_set = launch      ? NUM_CH'(1) :
                  enable_next ? (NUM_CH'(1) << nxt_idx[1:0]) : '0;

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      gap_cnt <= '0;
      nxt_idx <= '0;
    end else if (launch) begin
      gap_cnt <= '0;
      nxt_idx <= 3'd1;
    end else if (enable_next) begin
      gap_cnt <= '0;
      nxt_idx <= nxt_idx + 3'd1;
    end else if (state == S_START) begin
      gap_cnt <= gap_cnt + 4'd1;
    end
  end
`else
  assign all_started = 1'b1;
  assign en_set      = {NUM_CH{launch}};
`endif

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    stopped_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt = S_START;
          launch    = 1'b1;
        end
      end
      S_START: begin
        if (bus.stop)         state_nxt = S_STOP;
        else if (all_started) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.stop) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (ch_en == '0) begin
          state_nxt   = S_IDLE;
          stopped_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- channel stage: counters, toggles, low-phase freeze ----
  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      ch_en <= '0;
      clk_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en_set[i]) begin
          ch_en[i] <= 1'b1;
          cnt[i]   <= '0;
        end else if (ch_en[i]) begin
          // freezing only while low guarantees the last high phase is full length
          if (state == S_STOP && !clk_q[i]) begin
            ch_en[i] <= 1'b0;
            cnt[i]   <= '0;
            clk_q[i] <= 1'b0;
          end else if (hp[i] != '0) begin
            if (cnt[i] == hp[i] - HP_W'(1)) begin
              cnt[i]   <= '0;
              clk_q[i] <= ~clk_q[i];
            end else begin
              cnt[i] <= cnt[i] + HP_W'(1);
            end
          end
        end
      end
    end
  end

  // ---- register port: writes only land while idle ----
  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_CH; i++) hp[i] <= HP_W'(HP_RST);
      wr_err_q  <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      if (bus.wr_en && state == S_IDLE) hp[bus.wr_addr] <= bus.wr_data;
      wr_err_q  <= bus.wr_en && (state != S_IDLE);
      stopped_q <= stopped_nxt;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.running = (state == S_RUN);
  assign bus.busy    = (state == S_START) || (state == S_STOP);
  assign bus.wr_err  = wr_err_q;
  assign bus.stopped = stopped_q;

endmodule

// File: tb/tb_clk_div_seq_ctrl.sv
// Directed bench for clk_div_seq_ctrl; expected waveforms follow from hp, enable offsets and stop cycle.
module tb_clk_div_seq_ctrl;

`ifdef CLK_DIV_SEQ_STAGGER_EN
  localparam int GAP    = 4;
  localparam int DONE_A = 34;
`else
  localparam int GAP    = 0;
  localparam int DONE_A = 32;
`endif
  localparam int RUN_AT = 3 * GAP + 1;
  localparam int NEVER  = 1_000_000;

  logic clk_in = 1'b0;
  logic rst_b;
  always #5 clk_in = ~clk_in;

  clk_div_seq_if #(.NUM_CH(4), .HP_W(6)) bus ();

  clk_div_seq_ctrl #(.NUM_CH(4), .HP_W(6), .HP_RST(5), .START_GAP(4)) dut (
    .clk_in (clk_in),
    .rst_b  (rst_b),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int k, stop_k, done_k, wr_err_k;
  int hp_m [4];
  logic [3:0] frz;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b k=%0d", tag, obs, exp, k);
    end
  endtask

  // Channel i is enabled i*GAP cycles after start unless stop arrived first;
  // it then sits low for hp cycles and alternates every hp cycles.
  function automatic logic [3:0] model_clk();
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      int off;
      off = i * GAP;
      if (off < stop_k && k >= off && hp_m[i] != 0)
        v[i] = (((k - off) / hp_m[i]) % 2) == 1;
    end
    return v & ~frz;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
    k++;
  endtask

  task automatic sample_checks();
    logic [3:0] e;
    logic       run_e;
    e = model_clk();
    chk4("clk_out", bus.clk_out, e);
    if (k >= stop_k) frz = frz | ~e;
    run_e = (k >= RUN_AT) && (k < stop_k);
    chk1("running", bus.running, run_e);
    chk1("busy", bus.busy, !run_e && (k < done_k));
    chk1("stopped", bus.stopped, k == done_k);
    chk1("wr_err", bus.wr_err, k == wr_err_k);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      tick();
      sample_checks();
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk_in);
    #1;
    bus.start = 1'b0;
    k = 0; stop_k = NEVER; done_k = NEVER; wr_err_k = -1; frz = '0;
    sample_checks();
  endtask

  task automatic schedule_stop(input int done);
    bus.stop = 1'b1;
    stop_k   = k + 1;
    done_k   = done;
    run_cycles(1);
    bus.stop = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [5:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
    hp_m[addr]  = int'(data);
    chk1("wr_err_idle", bus.wr_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_b = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0;
    bus.wr_addr = 2'd0; bus.wr_data = 6'd0;
    k = 0; stop_k = NEVER; done_k = NEVER; wr_err_k = -1; frz = '0;
    for (int i = 0; i < 4; i++) hp_m[i] = 5;

    // reset values
    repeat (3) @(posedge clk_in);
    #1;
    chk4("rst_clk_out", bus.clk_out, 4'd0);
    chk1("rst_running", bus.running, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_wr_err", bus.wr_err, 1'b0);
    chk1("rst_stopped", bus.stopped, 1'b0);
    rst_b = 1'b1;
    tick();

    // default hp=5, rejected write in RUN, stop while ch0 high
    do_start();
    run_cycles(20);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 6'd7;
    wr_err_k = k + 1;
    run_cycles(1);
    bus.wr_en = 1'b0;
    run_cycles(5);
    chk1("ch0_high_at_stop", bus.clk_out[0], 1'b1);
    schedule_stop(DONE_A);
    run_cycles(9);

    // hp = {1,2,-,0}; ch2 must still run at hp 5
    wr(2'd0, 6'd1);
    wr(2'd1, 6'd2);
    wr(2'd3, 6'd0);
    do_start();
    run_cycles(20);
    schedule_stop(24);
    run_cycles(5);

    // start and stop together in IDLE: no transition
    bus.start = 1'b1; bus.stop = 1'b1;
    repeat (3) begin
      tick();
      chk1("both_busy", bus.busy, 1'b0);
      chk1("both_running", bus.running, 1'b0);
      chk4("both_clk_out", bus.clk_out, 4'd0);
    end
    bus.start = 1'b0; bus.stop = 1'b0;

    // early stop: stop sampled 6 cycles after start
    wr(2'd2, 6'd3);
    do_start();
    run_cycles(5);
    schedule_stop(10);
    run_cycles(5);

    // async reset mid-run, then hp back at 5
    do_start();
    run_cycles(16);
    rst_b = 1'b0;
    #2;
    chk4("arst_clk_out", bus.clk_out, 4'd0);
    chk1("arst_running", bus.running, 1'b0);
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_stopped", bus.stopped, 1'b0);
    #2;
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) hp_m[i] = 5;
    do_start();
    run_cycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
